id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
RV32I decode stage. It sits between the IF/ID register and EX, and drives the register-file read addresses. It decodes the instruction, generates the immediate, and bypasses the same-cycle writeback value into the operands. It detects load-use hazards and owns the ID/EX pipeline register, including valid, stall, bubble and flush handling.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
RESET_PC, 32'h0000_0000, value loaded into id_ex.pc at reset.

Ports:
clk  in  1  clock
Reset  in  1  asynchronous, active-high reset
if_valid  in  1  IF/ID holds a valid instruction
if_instr  in  32  instruction word
if_pc  in  32  PC of if_instr
rs1_addr  out  5  register-file read address 1; equals if_instr[19:15], combinational
rs2_addr  out  5  register-file read address 2; equals if_instr[24:20], combinational
rs1_data  in  32  register-file read data 1, combinational
rs2_data  in  32  register-file read data 2, combinational
wb_we  in  1  writeback write enable
wb_rd  in  5  writeback destination register
wb_data  in  32  writeback data
ex_stall  in  1  EX cannot accept; hold ID/EX
flush  in  1  branch/jump redirect; kill ID contents
stall_o  out  1  hold PC and IF/ID this cycle, combinational
id_ex  out  id_ex_t  registered ID/EX bundle (see Decomposition)
illegal_o  out  1  registered; present only with ILLEGAL_TRAP_EN

Behaviour:
- Reset (async) sets every id_ex field to 0 except pc=RESET_PC. illegal_o resets to 0, and stall_o is therefore 0.
- Latency is 1 cycle: an instruction accepted at edge N appears in id_ex after edge N.
- Next-state priority: Reset > flush > ex_stall > load-use > advance.
  - flush: id_ex.valid<=0 (bubble), even when ex_stall=1. stall_o=0.
  - ex_stall: id_ex holds all fields. stall_o=1.
  - load-use: the condition is if_valid & id_ex.valid & id_ex.mem_rd & id_ex.rd!=0 & ((rd==rs1 & uses_rs1) | (rd==rs2 & uses_rs2)).
    - Inserts a bubble: id_ex.valid<=0, other fields are don't-care.
    - stall_o=1 for exactly one cycle per hazard.
  - advance: id_ex<=decode(if_instr), valid<=if_valid.
- Operands:
  - rsX_val = 0 if rsX==0.
  - Otherwise rsX_val = wb_data if wb_we & wb_rd==rsX & wb_rd!=0.
  - Otherwise rsX_val = rsX_data.
- uses_rs1 is 0 for LUI, AUIPC and JAL. uses_rs2 is 1 only for OP, STORE and BRANCH.
- Immediates, all sign-extended from instr[31]:
  - I: [31:20]
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],0}
  - U: {[31:12],12'b0}
  - J: {[31],[19:12],[20],[30:21],0}
  - R-type: imm=0.
- ALU operation:
  - OP/OP-IMM: alu_op from funct3 and funct7[5]. SUB only for OP. SRA for either when funct7[5]=1.
  - LOAD/STORE/AUIPC/JAL/JALR: ADD.
  - LUI: PASSB.
  - BRANCH: SUB; the comparison kind is carried in funct3.
- Control bits:
  - reg_we=1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR.
  - id_ex.rd is forced to 0 when reg_we=0.
  - alu_src_pc=1 for AUIPC/JAL. alu_src_imm=1 for all except OP/BRANCH.
  - mem_size=funct3 for LOAD/STORE.
- Unknown opcodes decode as a NOP (valid kept, all control bits 0).
- Reset asserted mid-stall clears the stall and the bubble immediately.

Optional Feature:
ILLEGAL_TRAP_EN.
- Defined:
  - Unknown opcode, or a bad funct3/funct7 for OP, OP-IMM or shifts, sets illegal_o=1 with the instruction.
  - Control bits are 0; valid stays 1 so EX can trap.
  - Flush and bubble force illegal_o=0.
- Undefined: the port is absent and illegal instructions silently become NOPs.

Decomposition:
- Package rv32i_pkg:
  - Opcode localparams: OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC.
  - alu_op_e enum: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB.
  - imm_type_e enum: I, S, B, U, J, R.
  - id_ex_t struct: valid, pc[31:0], rs1_val, rs2_val, imm, rs1[4:0], rs2[4:0], rd[4:0], funct3, alu_op, alu_src_imm, alu_src_pc, reg_we, mem_rd, mem_wr, mem_size[2:0], branch, jal, jalr.
- One combinational sub-module, imm_gen (instr, imm_type -> imm[31:0]).

Test Plan:
- Reset, then if_instr=32'h00500093 (ADDI x1,x0,5), pc=0x40 -> next cycle: valid=1, rd=1, imm=5, alu_op=ADD, alu_src_imm=1, reg_we=1.
- LW x2,0(x1) (0x0000A103) followed by ADD x3,x2,x2 (0x002101B3):
  - stall_o=1 for one cycle and a bubble with valid=0.
  - The ADD then issues with rs1=rs2=2.
- ADD x6,x5,x0 (0x00028333) with rs1_data=0, wb_we=1, wb_rd=5, wb_data=0xDEADBEEF -> rs1_val=0xDEADBEEF, rs2_val=0.
- rs1=0 with rs1_data=0x1234, wb_we=1, wb_rd=0 -> rs1_val=0.
- BEQ x0,x0,-4 (0xFE000EE3) -> imm=0xFFFFFFFC, branch=1, reg_we=0, rd=0.
- ex_stall=1 holds id_ex for 3 cycles with stall_o=1. Then flush=1 with ex_stall=1 -> valid=0 next cycle. Reset pulsed mid-stall clears valid and stall_o asynchronously.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I decode types: opcodes, ALU operations, immediate formats and
// the ID/EX pipeline bundle.
package rv32i_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_R
    } imm_type_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        alu_op_e     alu_op;
        logic        alu_src_imm;
        logic        alu_src_pc;
        logic        reg_we;
        logic        mem_rd;
        logic        mem_wr;
        logic [2:0]  mem_size;
        logic        branch;
        logic        jal;
        logic        jalr;
    } id_ex_t;

    // alt is funct7[5]; SUB exists only for register-register OP.
    function automatic alu_op_e alu_decode(input logic [2:0] funct3,
                                           input logic       alt,
                                           input logic       is_op);
        alu_op_e op;
        case (funct3)
            3'b000:  op = (is_op && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: sign-extends the I/S/B/U/J immediate of an RV32I
// instruction; R-type yields zero.
module imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:0] instr,
    input  imm_type_e   imm_type,
    output logic [31:0] imm
);

    logic unused_opcode;
    assign unused_opcode = ^instr[6:0];

    always_comb begin
        imm = '0;
        case (imm_type)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage with writeback bypass, load-use detection and the ID/EX
// register. Optional illegal-instruction flag: define ILLEGAL_TRAP_EN.
module id_stage
    import rv32i_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
    input  logic            clk,
    input  logic            Reset,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [31:0]     if_pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_stall,
    input  logic            flush,
    output logic            stall_o,
    output id_ex_t          id_ex
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic            illegal_o
`endif
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd_field;
    logic [31:0] rs1_val, rs2_val, imm;

    imm_type_e imm_type;
    alu_op_e   alu_op;
    logic      uses_rs1, uses_rs2, illegal;
    logic      reg_we, alu_src_imm, alu_src_pc, mem_rd, mem_wr, branch, jal, jalr;
    logic      load_use;

    id_ex_t dec, id_ex_d, id_ex_q;

    assign opcode   = if_instr[6:0];
    assign rd_field = if_instr[11:7];
    assign funct3   = if_instr[14:12];
    assign funct7   = if_instr[31:25];
    assign rs1_addr = if_instr[19:15];
    assign rs2_addr = if_instr[24:20];

    imm_gen u_imm_gen (
        .instr    (if_instr),
        .imm_type (imm_type),
        .imm      (imm)
    );

    // Same-cycle writeback wins over the register file; x0 always reads zero.
    always_comb begin
        rs1_val = rs1_data;
        rs2_val = rs2_data;
        if (rs1_addr == 5'd0)
            rs1_val = '0;
        else if (wb_we && wb_rd == rs1_addr)
            rs1_val = wb_data;
        if (rs2_addr == 5'd0)
            rs2_val = '0;
        else if (wb_we && wb_rd == rs2_addr)
            rs2_val = wb_data;
    end

    always_comb begin
        imm_type    = IMM_R;
        alu_op      = ALU_ADD;
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b0;
        illegal     = 1'b0;
        reg_we      = 1'b0;
        alu_src_imm = 1'b0;
        alu_src_pc  = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        branch      = 1'b0;
        jal         = 1'b0;
        jalr        = 1'b0;
        case (opcode)
            OPC_OP: begin
                uses_rs2 = 1'b1;
                reg_we   = 1'b1;
                alu_op   = alu_decode(funct3, funct7[5], 1'b1);
                illegal  = !(funct7 == 7'b0000000 ||
                             (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
            end
            OPC_OP_IMM: begin
                imm_type    = IMM_I;
                reg_we      = 1'b1;
                alu_src_imm = 1'b1;
                alu_op      = alu_decode(funct3, funct7[5], 1'b0);
                illegal     = (funct3 == 3'b001 && funct7 != 7'b0000000) ||
                              (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000);
            end
            OPC_LOAD: begin
                imm_type    = IMM_I;
                reg_we      = 1'b1;
                alu_src_imm = 1'b1;
                mem_rd      = 1'b1;
            end
            OPC_STORE: begin
                imm_type    = IMM_S;
                uses_rs2    = 1'b1;
                alu_src_imm = 1'b1;
                mem_wr      = 1'b1;
            end
            OPC_BRANCH: begin
                imm_type = IMM_B;
                uses_rs2 = 1'b1;
                alu_op   = ALU_SUB;
                branch   = 1'b1;
            end
            OPC_JAL: begin
                imm_type    = IMM_J;
                uses_rs1    = 1'b0;
                reg_we      = 1'b1;
                alu_src_imm = 1'b1;
                alu_src_pc  = 1'b1;
                jal         = 1'b1;
            end
            OPC_JALR: begin
                imm_type    = IMM_I;
                reg_we      = 1'b1;
                alu_src_imm = 1'b1;
                jalr        = 1'b1;
            end
            OPC_LUI: begin
                imm_type    = IMM_U;
                uses_rs1    = 1'b0;
                reg_we      = 1'b1;
                alu_src_imm = 1'b1;
                alu_op      = ALU_PASSB;
            end
            OPC_AUIPC: begin
                imm_type    = IMM_U;
                uses_rs1    = 1'b0;
                reg_we      = 1'b1;
                alu_src_imm = 1'b1;
                alu_src_pc  = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        // Illegal encodings travel down the pipe as NOPs.
        if (illegal) begin
            alu_op      = ALU_ADD;
            reg_we      = 1'b0;
            alu_src_imm = 1'b0;
            alu_src_pc  = 1'b0;
            mem_rd      = 1'b0;
            mem_wr      = 1'b0;
            branch      = 1'b0;
            jal         = 1'b0;
            jalr        = 1'b0;
        end
    end

    always_comb begin
        dec             = '0;
        dec.valid       = if_valid;
        dec.pc          = if_pc;
        dec.rs1_val     = rs1_val;
        dec.rs2_val     = rs2_val;
        dec.imm         = imm;
        dec.rs1         = rs1_addr;
        dec.rs2         = rs2_addr;
        dec.rd          = reg_we ? rd_field : 5'd0;
        dec.funct3      = funct3;
        dec.alu_op      = alu_op;
        dec.alu_src_imm = alu_src_imm;
        dec.alu_src_pc  = alu_src_pc;
        dec.reg_we      = reg_we;
        dec.mem_rd      = mem_rd;
        dec.mem_wr      = mem_wr;
        dec.mem_size    = (mem_rd || mem_wr) ? funct3 : 3'd0;
        dec.branch      = branch;
        dec.jal         = jal;
        dec.jalr        = jalr;
    end

    assign load_use = if_valid && id_ex_q.valid && id_ex_q.mem_rd && id_ex_q.rd != 5'd0 &&
                      ((id_ex_q.rd == rs1_addr && uses_rs1) ||
                       (id_ex_q.rd == rs2_addr && uses_rs2));

    // Handshake: id_ex.valid marks a live instruction for EX; stall_o=1 means
    // IF must hold PC and IF/ID because this stage did not consume if_instr.
    assign stall_o = !Reset && !flush && (ex_stall || load_use);

    always_comb begin
        id_ex_d = id_ex_q;
        if (flush) begin
            id_ex_d.valid = 1'b0;
        end else if (ex_stall) begin
            id_ex_d = id_ex_q;
        end else if (load_use) begin
            id_ex_d.valid = 1'b0;
        end else begin
            id_ex_d = dec;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            id_ex_q    <= '0;
            id_ex_q.pc <= RESET_PC;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    assign id_ex = id_ex_q;

`ifdef ILLEGAL_TRAP_EN
    logic illegal_d, illegal_q;

    always_comb begin
        illegal_d = illegal_q;
        if (flush || (!ex_stall && load_use))
            illegal_d = 1'b0;
        else if (!ex_stall)
            illegal_d = illegal && if_valid;
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset)
            illegal_q <= 1'b0;
        else
            illegal_q <= illegal_d;
    end

    assign illegal_o = illegal_q;
`endif

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode, immediates, bypass, load-use bubble,
// EX stall hold, flush and asynchronous reset.
module tb_id_stage;
    import rv32i_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        Reset;
    logic        if_valid;
    logic [31:0] if_instr, if_pc;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_stall, flush, stall_o;
    id_ex_t      id_ex;

    int tests = 0;
    int fails = 0;

    id_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk      (clk),
        .Reset    (Reset),
        .if_valid (if_valid),
        .if_instr (if_instr),
        .if_pc    (if_pc),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .wb_we    (wb_we),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .ex_stall (ex_stall),
        .flush    (flush),
        .stall_o  (stall_o),
        .id_ex    (id_ex)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
        if_valid = 1'b1;
        if_instr = instr;
        if_pc    = pc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0;
        rs1_data = '0; rs2_data = '0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        ex_stall = 1'b1; flush = 1'b0;
        #12;
        check("rst_valid",   32'(id_ex.valid), 32'd0);
        check("rst_pc",      id_ex.pc, RST_PC);
        check("rst_imm",     id_ex.imm, 32'd0);
        check("rst_reg_we",  32'(id_ex.reg_we), 32'd0);
        check("rst_stall_o", 32'(stall_o), 32'd0);
        Reset = 1'b0; ex_stall = 1'b0;

        // ADDI x1,x0,5
        drive(32'h00500093, 32'h40);
        #1 check("addi_rs1_addr", 32'(rs1_addr), 32'd0);
        check("addi_rs2_addr", 32'(rs2_addr), 32'd5);
        step();
        check("addi_valid",   32'(id_ex.valid), 32'd1);
        check("addi_pc",      id_ex.pc, 32'h40);
        check("addi_rd",      32'(id_ex.rd), 32'd1);
        check("addi_imm",     id_ex.imm, 32'd5);
        check("addi_alu_op",  32'(id_ex.alu_op), 32'(ALU_ADD));
        check("addi_src_imm", 32'(id_ex.alu_src_imm), 32'd1);
        check("addi_reg_we",  32'(id_ex.reg_we), 32'd1);

        // LW x2,0(x1) then dependent ADD x3,x2,x2
        drive(32'h0000A103, 32'h44);
        step();
        check("lw_mem_rd",   32'(id_ex.mem_rd), 32'd1);
        check("lw_rd",       32'(id_ex.rd), 32'd2);
        check("lw_mem_size", 32'(id_ex.mem_size), 32'd2);
        drive(32'h002101B3, 32'h48);
        rs1_data = 32'h11; rs2_data = 32'h22;
        #1 check("lu_stall_o", 32'(stall_o), 32'd1);
        step();
        check("lu_bubble_valid", 32'(id_ex.valid), 32'd0);
        check("lu_stall_release", 32'(stall_o), 32'd0);
        step();
        check("add_valid",   32'(id_ex.valid), 32'd1);
        check("add_pc",      id_ex.pc, 32'h48);
        check("add_rs1",     32'(id_ex.rs1), 32'd2);
        check("add_rs2",     32'(id_ex.rs2), 32'd2);
        check("add_rd",      32'(id_ex.rd), 32'd3);
        check("add_rs1_val", id_ex.rs1_val, 32'h11);
        check("add_rs2_val", id_ex.rs2_val, 32'h22);
        check("add_src_imm", 32'(id_ex.alu_src_imm), 32'd0);

        // ADD x6,x5,x0 with writeback bypass of x5
        drive(32'h00028333, 32'h4C);
        rs1_data = 32'h0; rs2_data = 32'h5555;
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
        step();
        check("byp_rs1_val", id_ex.rs1_val, 32'hDEADBEEF);
        check("byp_rs2_val", id_ex.rs2_val, 32'h0);
        check("byp_rd",      32'(id_ex.rd), 32'd6);

        // ADDI x7,x0,1: x0 never bypassed
        drive(32'h00100393, 32'h50);
        rs1_data = 32'h1234; wb_rd = 5'd0; wb_data = 32'hCAFE;
        step();
        check("x0_rs1_val", id_ex.rs1_val, 32'h0);
        check("x0_imm",     id_ex.imm, 32'd1);
        wb_we = 1'b0;

        // BEQ x0,x0,-4
        drive(32'hFE000EE3, 32'h54);
        step();
        check("beq_imm",    id_ex.imm, 32'hFFFFFFFC);
        check("beq_branch", 32'(id_ex.branch), 32'd1);
        check("beq_reg_we", 32'(id_ex.reg_we), 32'd0);
        check("beq_rd",     32'(id_ex.rd), 32'd0);
        check("beq_alu_op", 32'(id_ex.alu_op), 32'(ALU_SUB));

        // LUI x5,0x12345
        drive(32'h123452B7, 32'h58);
        step();
        check("lui_imm",    id_ex.imm, 32'h12345000);
        check("lui_alu_op", 32'(id_ex.alu_op), 32'(ALU_PASSB));
        check("lui_rd",     32'(id_ex.rd), 32'd5);

        // JAL x1,+8
        drive(32'h008000EF, 32'h5C);
        step();
        check("jal_imm",    id_ex.imm, 32'd8);
        check("jal_jal",    32'(id_ex.jal), 32'd1);
        check("jal_src_pc", 32'(id_ex.alu_src_pc), 32'd1);
        check("jal_rd",     32'(id_ex.rd), 32'd1);

        // SRAI x1,x1,3 and SUB x1,x2,x3
        drive(32'h4030D093, 32'h60);
        step();
        check("srai_alu_op", 32'(id_ex.alu_op), 32'(ALU_SRA));
        drive(32'h403100B3, 32'h64);
        step();
        check("sub_alu_op", 32'(id_ex.alu_op), 32'(ALU_SUB));

        // Unknown opcode with rd field 31 decodes as NOP
        drive(32'h00000FFF, 32'h68);
        step();
        check("nop_valid",  32'(id_ex.valid), 32'd1);
        check("nop_reg_we", 32'(id_ex.reg_we), 32'd0);
        check("nop_rd",     32'(id_ex.rd), 32'd0);

        // SW x2,-4(x1)
        drive(32'hFE20AE23, 32'h6C);
        step();
        check("sw_imm",      id_ex.imm, 32'hFFFFFFFC);
        check("sw_mem_wr",   32'(id_ex.mem_wr), 32'd1);
        check("sw_mem_size", 32'(id_ex.mem_size), 32'd2);
        check("sw_rd",       32'(id_ex.rd), 32'd0);

        // EX stall holds the SW for three cycles
        drive(32'h00500093, 32'h70);
        ex_stall = 1'b1;
        #1 check("exs_stall_o", 32'(stall_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("exs_hold_valid", 32'(id_ex.valid), 32'd1);
            check("exs_hold_pc",    id_ex.pc, 32'h6C);
            check("exs_hold_mem_wr", 32'(id_ex.mem_wr), 32'd1);
            check("exs_hold_stall", 32'(stall_o), 32'd1);
        end

        // Flush overrides the EX stall
        flush = 1'b1;
        #1 check("flush_stall_o", 32'(stall_o), 32'd0);
        step();
        check("flush_valid", 32'(id_ex.valid), 32'd0);
        flush = 1'b0; ex_stall = 1'b0;

        // No valid instruction from IF gives an empty slot
        if_valid = 1'b0;
        step();
        check("idle_valid", 32'(id_ex.valid), 32'd0);

        // Reset in the middle of a load-use plus EX stall
        drive(32'h0000A103, 32'h80);
        step();
        drive(32'h002101B3, 32'h84);
        ex_stall = 1'b1;
        #1 check("rst_mid_stall_before", 32'(stall_o), 32'd1);
        #1 Reset = 1'b1;
        #1 check("rst_mid_valid",   32'(id_ex.valid), 32'd0);
        check("rst_mid_pc",      id_ex.pc, RST_PC);
        check("rst_mid_stall_o", 32'(stall_o), 32'd0);
        #1 Reset = 1'b0; ex_stall = 1'b0;
        #1 check("rst_mid_no_lu", 32'(stall_o), 32'd0);
        step();
        check("post_rst_valid", 32'(id_ex.valid), 32'd1);
        check("post_rst_rd",    32'(id_ex.rd), 32'd3);
        check("post_rst_pc",    id_ex.pc, 32'h84);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
